sigmoid_pla_sched: RTL

Round-robin scheduler and configuration front-end for the PLA sigmoid datapath in the VAE. It shares one gradient·x ± offset evaluator between `NREQ` requesters, such as encoder/decoder activation lanes. For each accepted sample it picks the PLA segment from a programmable breakpoint table and pipelines the multiply-add. It returns the result with the requester's ID over a valid/ready output.

---
 rtl/sigmoid_pkg.sv | 16 +
 rtl/sigmoid_seg_sel.sv | 32 +++
 rtl/sigmoid_pla_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sigmoid_pkg.sv
// Shared defaults and configuration-select encoding for the PLA sigmoid scheduler.
package sigmoid_pkg;

  localparam int unsigned BITS = 16;
  localparam int unsigned FRAC = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned NSEG = 4;

  typedef enum logic [1:0] {
    CFG_GRAD = 2'd0,
    CFG_OFFS = 2'd1,
    CFG_BP   = 2'd2,
    CFG_RSVD = 2'd3
  } cfg_sel_e;

endpackage

// File: rtl/sigmoid_seg_sel.sv
// Segment selection: |x| (clamped at the most negative code) compared against
// the ascending breakpoint table; seg is the number of breakpoints at or below |x|.
module sigmoid_seg_sel #(
  parameter int unsigned BITS = sigmoid_pkg::BITS,
  parameter int unsigned NSEG = sigmoid_pkg::NSEG,
  localparam int unsigned SEGW = $clog2(NSEG)
) (
  input  logic [BITS-1:0]          i_x,
  input  logic [(NSEG-1)*BITS-1:0] i_bp,
  output logic [SEGW-1:0]          o_seg_c
);
  import sigmoid_pkg::*;

  localparam logic [BITS-1:0] X_MIN   = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] MAG_MAX = {1'b0, {(BITS-1){1'b1}}};

  logic [BITS-1:0] w_mag;

  always_comb begin
    w_mag   = i_x;
    o_seg_c = '0;
    if (i_x[BITS-1]) begin
      w_mag = (i_x == X_MIN) ? MAG_MAX : BITS'(-i_x);
    end
    for (int i = 0; i < int'(NSEG) - 1; i++) begin
      if ($signed(w_mag) >= $signed(i_bp[i*BITS +: BITS])) begin
        o_seg_c = o_seg_c + SEGW'(1);
      end
    end
  end

endmodule

// File: rtl/sigmoid_pla_sched.sv
// Round-robin front-end sharing one PLA sigmoid evaluator between NREQ requesters:
// programmable tables, stage-1 segment/coefficient capture, stage-2 multiply-add.
module sigmoid_pla_sched #(
  parameter int unsigned BITS = sigmoid_pkg::BITS,
  parameter int unsigned FRAC = sigmoid_pkg::FRAC,
  parameter int unsigned NREQ = sigmoid_pkg::NREQ,
  parameter int unsigned NSEG = sigmoid_pkg::NSEG,
  localparam int unsigned SEGW = $clog2(NSEG),
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*BITS-1:0] req_x,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [SEGW-1:0]      cfg_addr,
  input  logic [BITS-1:0]      cfg_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS-1:0]      out_data,
  output logic [IDW-1:0]       out_id
);
  import sigmoid_pkg::*;

  localparam logic [BITS-1:0] BP_RST = {1'b0, {(BITS-1){1'b1}}};

  // Coefficient tables
  logic [BITS-1:0]          r_grad [NSEG];
  logic [BITS-1:0]          r_offs [NSEG];
  logic [(NSEG-1)*BITS-1:0] r_bp;

  // Arbiter
  logic [IDW-1:0]  r_rr;
  logic [IDW:0]    w_idx;
  logic            w_found;
  logic [IDW-1:0]  w_grant_idx;
  logic [NREQ-1:0] w_grant;
  logic            w_accept;
  logic            w_stall;
  logic [BITS-1:0] w_x;
  logic [SEGW-1:0] w_seg;

  // Stage 1
  logic            r_s1_valid;
  logic [BITS-1:0] r_s1_x;
  logic [IDW-1:0]  r_s1_id;
  logic [BITS-1:0] r_s1_grad;
  logic [BITS-1:0] r_s1_offs;

  // Stage 2 / output
  logic signed [2*BITS-1:0] w_prod;
  logic [BITS-1:0]          w_eval;
  logic                     r_out_valid;
  logic [BITS-1:0]          r_out_data;
  logic [IDW-1:0]           r_out_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NSEG); i++) begin
        r_grad[i] <= '0;
        r_offs[i] <= '0;
      end
      r_bp <= {(NSEG-1){BP_RST}};
    end else if (cfg_we) begin
      case (cfg_sel_e'(cfg_sel))
        CFG_GRAD: r_grad[cfg_addr] <= cfg_data;
        CFG_OFFS: r_offs[cfg_addr] <= cfg_data;
        CFG_BP: begin
          if (32'(cfg_addr) < NSEG - 1) begin
            r_bp[cfg_addr*BITS +: BITS] <= cfg_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_stall = r_out_valid & ~out_ready;

  // First valid requester at or after rr, modulo NREQ; suppressed during stall/reset
  always_comb begin
    w_idx       = '0;
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_grant     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_rr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_idx[IDW-1:0];
      end
    end
    if (w_found && !w_stall && rst_n) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;
  assign w_x       = req_x[w_grant_idx*BITS +: BITS];

  sigmoid_seg_sel #(
    .BITS (BITS),
    .NSEG (NSEG)
  ) u_seg_sel (
    .i_x     (w_x),
    .i_bp    (r_bp),
    .o_seg_c (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_accept) begin
      r_rr <= (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + IDW'(1);
    end
  end

  // Stage 1: coefficients are captured here so later table writes never reach in-flight samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_id    <= '0;
      r_s1_grad  <= '0;
      r_s1_offs  <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_x    <= w_x;
        r_s1_id   <= w_grant_idx;
        r_s1_grad <= r_grad[w_seg];
        r_s1_offs <= r_offs[w_seg];
      end
    end
  end

  // Stage 2: (x*grad)>>>FRAC +/- offset, wrapping
  always_comb begin
    w_prod = (2*BITS)'($signed(r_s1_x)) * (2*BITS)'($signed(r_s1_grad));
    w_eval = BITS'(w_prod >>> FRAC)
           + (r_s1_x[BITS-1] ? BITS'(-r_s1_offs) : r_s1_offs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_eval;
        r_out_id   <= r_s1_id;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

endmodule
